calc_entry_ctrl: RTL
====================

Name: calc_entry_ctrl

Overview:
- Parametrised keypad-driven calculator controller, the successor to the fixed 16-bit input-screen FSM.
- Accumulates hex digits into operand A, then operand B, accepts an operator, computes with an internal ALU, and drives the display register.
- Adds: WIDTH generalisation, single-cycle key strobe, backspace and clear-entry keys, result chaining, and a registered overflow flag.
- Sits between the keypad decoder (key/key_valid) and the 7-segment display driver (display).

Parameters:
- WIDTH, 16, operand/result/display width in bits; must be a multiple of 4, minimum 8.
- ENTER_KEY, 5'h13, key code that commits the current entry.
- CLR_KEY, 5'h16, key code that clears the current entry to zero.
- BKSP_KEY, 5'h17, key code that deletes the last digit.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- key  in  5  key code; key[4]=0 means hex digit key[3:0]; key[4]=1 means command/operator.
- key_valid  in  1  one-cycle strobe qualifying key; key is ignored when low.
- display  out  WIDTH  value shown on screen (entry in progress, or result).
- op_a  out  WIDTH  committed operand A.
- op_b  out  WIDTH  committed operand B.
- op_sel  out  3  committed operator code.
- result_valid  out  1  high while in SHOW.
- overflow  out  1  overflow of the last computation; valid while result_valid=1.
- state_dbg  out  3  encoded current state, for LEDs.

Behaviour:
- Reset (async, rst=1): state=ENTRY_A; display, op_a, op_b=0; op_sel=3'b000; result_valid=0; overflow=0.
- All state and outputs are registered. Each key event takes effect on the clock edge where key_valid=1.
- States and encoding: ENTRY_A=0, ENTRY_B=1, ENTRY_OP=2, COMPUTE=3, SHOW=4.
- Digit entry (ENTRY_A/ENTRY_B, key[4]=0):
  - display <= {display[WIDTH-5:0], key[3:0]}.
  - If display[WIDTH-1:WIDTH-4] != 0 the entry is full and the key is ignored; no wrap, no shifting out.
- CLR_KEY in ENTRY_A/ENTRY_B: display <= 0.
- BKSP_KEY in ENTRY_A/ENTRY_B: display <= display >> 4 (logical).
- ENTER_KEY transitions:
  - ENTRY_A: op_a <= display; display <= 0; go to ENTRY_B.
  - ENTRY_B: op_b <= display; display <= 0; go to ENTRY_OP.
- Operator keys (ENTRY_OP): key in {5'h10,5'h11,5'h12,5'h14,5'h15} sets op_sel <= key[2:0]. Codes: 000 ADD, 001 SUB, 010 AND, 100 OR, 101 XOR. The last operator pressed wins. display shows {WIDTH-3 zeros, op_sel} as feedback.
- ENTER_KEY in ENTRY_OP: go to COMPUTE.
- COMPUTE (exactly 1 cycle, no key accepted):
  - display <= ALU(op_a, op_b, op_sel), truncated to WIDTH.
  - overflow <= carry-out for ADD, borrow (op_a < op_b unsigned) for SUB, 0 for logic ops.
  - Go to SHOW.
- Latency: 2 clock edges from the ENTER edge in ENTRY_OP to result_valid=1.
- SHOW (result_valid=1): display holds the result until a key arrives.
  - Digit key: display <= {0, digit}; overflow <= 0; go to ENTRY_A (new calculation).
  - ENTER_KEY (chaining): op_a <= display; display <= 0; overflow <= 0; go to ENTRY_B.
  - CLR_KEY: display <= 0; overflow <= 0; go to ENTRY_A.
  - Other keys: ignored.
- Ignored keys: any key not listed for the current state is ignored, with no state or output change.
- key_valid held high across multiple cycles counts as one key per cycle. Debounce and one-shot are upstream responsibilities.
- Reset asserted mid-operation (any state, including COMPUTE) returns immediately to the reset values.

Optional Feature:
- Macro CALC_ENTRY_SAT_EN.
- Defined: on overflow, display is saturated: ADD gives all ones, SUB gives 0. The overflow flag is still set.
- Undefined: the wrapped, truncated result is displayed. No saturation logic is present.

Test Plan:
- WIDTH=16, keys 1,2,ENTER,3,4,ENTER,0x10,ENTER -> op_a=0x0012, op_b=0x0034, display=0x0046 two cycles after the last ENTER, result_valid=1, overflow=0.
- Keys F,F,F,F,ENTER,0,0,0,1,ENTER,0x10,ENTER -> display=0x0000 with overflow=1; with CALC_ENTRY_SAT_EN, display=0xFFFF with overflow=1.
- Keys 1,2,3,4,5 in ENTRY_A -> display=0x1234 (fifth digit ignored); then BKSP -> 0x0123; then CLR -> 0x0000.
- Keys 5,ENTER,7,ENTER,0x11,ENTER -> display=0xFFFE, overflow=1; then ENTER, 2, ENTER, 0x14, ENTER -> op_a=0xFFFE, display=0xFFFE (OR with 0x0002), overflow=0.
- Assert rst for one cycle while in ENTRY_OP with op_sel=0x5 -> all outputs 0 and state_dbg=0 without waiting for a clock edge; the next digit enters operand A.
- In ENTRY_OP press 0x12, then 0x15, then ENTER with op_a=0x00F0, op_b=0x0FF0 -> op_sel=101, display=0x0F00.

Source files
------------

// File: rtl/calc_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : calc_entry_ctrl
// Brief    : Keypad calculator entry controller. Keys build operand A and
//            operand B and select an operator. The built-in ALU then produces
//            the result and a registered overflow flag for the display.
//            Define CALC_ENTRY_SAT_EN to saturate ADD/SUB results on overflow.
// Revision : 1.0 - initial release
// ============================================================================
module calc_entry_ctrl #(
  parameter int         WIDTH     = 16,
  parameter logic [4:0] ENTER_KEY = 5'h13,
  parameter logic [4:0] CLR_KEY   = 5'h16,
  parameter logic [4:0] BKSP_KEY  = 5'h17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       key,
  input  logic             key_valid,
  output logic [WIDTH-1:0] display,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [2:0]       op_sel,
  output logic             result_valid,
  output logic             overflow,
  output logic [2:0]       state_dbg
);

  localparam logic [2:0] c_ST_ENTRY_A  = 3'd0;
  localparam logic [2:0] c_ST_ENTRY_B  = 3'd1;
  localparam logic [2:0] c_ST_ENTRY_OP = 3'd2;
  localparam logic [2:0] c_ST_COMPUTE  = 3'd3;
  localparam logic [2:0] c_ST_SHOW     = 3'd4;

  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_SUB = 3'b001;
  localparam logic [2:0] c_OP_AND = 3'b010;
  localparam logic [2:0] c_OP_OR  = 3'b100;
  localparam logic [2:0] c_OP_XOR = 3'b101;

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] display_q, display_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [2:0]       op_sel_q, op_sel_d;
  logic             overflow_q, overflow_d;
  logic             result_valid_q;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_alu_res;
  logic [WIDTH-1:0] w_alu_disp;
  logic             w_alu_ovf;
  logic             w_is_digit;
  logic             w_entry_full;
  logic             w_is_op_key;

  // One extra bit captures carry-out on ADD and borrow on SUB.
  assign w_sum        = {1'b0, op_a_q} + {1'b0, op_b_q};
  assign w_diff       = {1'b0, op_a_q} - {1'b0, op_b_q};
  assign w_is_digit   = ~key[4];
  assign w_entry_full = (display_q[WIDTH-1 -: 4] != 4'h0);

  always_comb begin
    w_is_op_key = 1'b0;
    case (key)
      5'h10, 5'h11, 5'h12, 5'h14, 5'h15: w_is_op_key = 1'b1;
      default:                           w_is_op_key = 1'b0;
    endcase
  end

  always_comb begin
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    case (op_sel_q)
      c_OP_ADD: begin
        w_alu_res = w_sum[WIDTH-1:0];
        w_alu_ovf = w_sum[WIDTH];
      end
      c_OP_SUB: begin
        w_alu_res = w_diff[WIDTH-1:0];
        w_alu_ovf = w_diff[WIDTH];
      end
      c_OP_AND: w_alu_res = op_a_q & op_b_q;
      c_OP_OR:  w_alu_res = op_a_q | op_b_q;
      c_OP_XOR: w_alu_res = op_a_q ^ op_b_q;
      default:  w_alu_res = '0;
    endcase
  end

`ifdef CALC_ENTRY_SAT_EN
  // Only ADD and SUB can raise overflow, so SUB clamps low and ADD clamps high.
  always_comb begin
    w_alu_disp = w_alu_res;
    if (w_alu_ovf) begin
      w_alu_disp = (op_sel_q == c_OP_SUB) ? '0 : '1;
    end
  end
`else
  assign w_alu_disp = w_alu_res;
`endif

  always_comb begin
    state_d    = state_q;
    display_d  = display_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_sel_d   = op_sel_q;
    overflow_d = overflow_q;
    case (state_q)
      c_ST_ENTRY_A, c_ST_ENTRY_B: begin
        if (key_valid) begin
          if (w_is_digit) begin
            if (!w_entry_full) begin
              display_d = {display_q[WIDTH-5:0], key[3:0]};
            end
          end else if (key == ENTER_KEY) begin
            display_d = '0;
            if (state_q == c_ST_ENTRY_A) begin
              op_a_d  = display_q;
              state_d = c_ST_ENTRY_B;
            end else begin
              op_b_d  = display_q;
              state_d = c_ST_ENTRY_OP;
            end
          end else if (key == CLR_KEY) begin
            display_d = '0;
          end else if (key == BKSP_KEY) begin
            display_d = display_q >> 4;
          end
        end
      end
      c_ST_ENTRY_OP: begin
        if (key_valid) begin
          if (w_is_op_key) begin
            op_sel_d  = key[2:0];
            display_d = {{(WIDTH-3){1'b0}}, key[2:0]};
          end else if (key == ENTER_KEY) begin
            state_d = c_ST_COMPUTE;
          end
        end
      end
      c_ST_COMPUTE: begin
        display_d  = w_alu_disp;
        overflow_d = w_alu_ovf;
        state_d    = c_ST_SHOW;
      end
      c_ST_SHOW: begin
        if (key_valid) begin
          if (w_is_digit) begin
            display_d  = {{(WIDTH-4){1'b0}}, key[3:0]};
            overflow_d = 1'b0;
            state_d    = c_ST_ENTRY_A;
          end else if (key == ENTER_KEY) begin
            op_a_d     = display_q;
            display_d  = '0;
            overflow_d = 1'b0;
            state_d    = c_ST_ENTRY_B;
          end else if (key == CLR_KEY) begin
            display_d  = '0;
            overflow_d = 1'b0;
            state_d    = c_ST_ENTRY_A;
          end
        end
      end
      default: state_d = c_ST_ENTRY_A;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= c_ST_ENTRY_A;
      display_q      <= '0;
      op_a_q         <= '0;
      op_b_q         <= '0;
      op_sel_q       <= c_OP_ADD;
      overflow_q     <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      display_q      <= display_d;
      op_a_q         <= op_a_d;
      op_b_q         <= op_b_d;
      op_sel_q       <= op_sel_d;
      overflow_q     <= overflow_d;
      result_valid_q <= (state_d == c_ST_SHOW);
    end
  end

  assign display      = display_q;
  assign op_a         = op_a_q;
  assign op_b         = op_b_q;
  assign op_sel       = op_sel_q;
  assign overflow     = overflow_q;
  assign result_valid = result_valid_q;
  assign state_dbg    = state_q;

endmodule
`default_nettype wire
